// File: rtl/mips_pkg.sv
// mips_pkg: op_sel classes, shared opcodes and instruction field positions
package mips_pkg;
  typedef enum logic [2:0] {OP_LW, OP_SW, OP_RTYPE, OP_ADDI, OP_BEQ, OP_J} op_sel_e;
  localparam logic [5:0] OPC_LW = 6'b100011;
  localparam logic [5:0] OPC_SW = 6'b101011;
  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_ADDI = 6'b001000;
  localparam logic [5:0] OPC_BEQ = 6'b000100;
  localparam logic [5:0] OPC_J = 6'b000010;
  localparam int OPC_LSB = 26;
  localparam int RS_LSB = 21;
  localparam int RT_LSB = 16;
  localparam int RD_LSB = 11;
  localparam int SHAMT_LSB = 6;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_LSB = 0;
  localparam int TARGET_LSB = 0;
  function automatic logic [5:0] opcode(input op_sel_e op);
    return op == OP_LW ? OPC_LW :
           op == OP_SW ? OPC_SW :
           op == OP_ADDI ? OPC_ADDI :
           op == OP_BEQ ? OPC_BEQ :
           op == OP_J ? OPC_J : OPC_RTYPE;
  endfunction
endpackage

// File: rtl/instr_pack.sv
// instr_pack: combinational packer of instruction fields into a MIPS word with legality flag
module instr_pack
  import mips_pkg::*;
(
  input  logic [2:0]  op_sel,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        legal
);
  op_sel_e op;
  assign op = op_sel_e'(op_sel);
  assign legal = op_sel <= 3'd5;
  always_comb begin
    word = '0;
    word[OPC_LSB +: 6] = opcode(op);
    if (op == OP_J) word[TARGET_LSB +: 26] = target;
    else begin
      word[RS_LSB +: 5] = rs;
      word[RT_LSB +: 5] = rt;
      if (op == OP_RTYPE) begin
        word[RD_LSB +: 5] = rd;
        word[SHAMT_LSB +: 5] = shamt;
        word[FUNCT_LSB +: 6] = funct;
      end else word[IMM_LSB +: 16] = imm;
    end
  end
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: packs instruction fields into addressed MIPS words on a valid/ready stream
module instr_encoder
  import mips_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op_sel,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  input  logic              addr_load,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_word,
  output logic [ADDR_W-1:0] out_addr,
  output logic [15:0]       word_count,
  output logic              err
);
  logic [31:0] word;
  logic legal, acc, take;
  logic [ADDR_W-1:0] next_addr;
  instr_pack u_pack (
    .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .funct(funct), .imm(imm), .target(target), .word(word), .legal(legal)
  );
  assign in_ready = !addr_load && (!out_valid || out_ready);
  assign acc = in_valid && in_ready;
  assign take = acc && legal;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_word <= '0;
      out_addr <= '0;
      next_addr <= BASE_ADDR;
      word_count <= '0;
      err <= 1'b0;
    end else begin
      err <= acc && !legal;
      out_valid <= take || (out_valid && !out_ready);
      next_addr <= addr_load ? BASE_ADDR : take ? next_addr + ADDR_W'(4) : next_addr;
      if (take) begin
        out_word <= word;
        out_addr <= next_addr;
        word_count <= word_count + 16'(word_count != '1);
      end
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: randomized and directed checks of instr_encoder against a behavioural model
module tb_instr_encoder;
  logic clk = 0;
  logic rst_n, in_valid, addr_load, out_ready;
  logic [2:0] op_sel;
  logic [4:0] rs, rt, rd, shamt;
  logic [5:0] funct;
  logic [15:0] imm;
  logic [25:0] target;
  logic rdy [3], ov [3], er [3];
  logic [31:0] ow [3];
  logic [15:0] wc [3];
  logic [31:0] oa0, oa1;
  logic [3:0] oa2;
  int tests = 0, fails = 0;
  localparam logic [31:0] BASE [3] = '{32'h0, 32'h400, 32'h0};
  localparam logic [31:0] MASK [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hF};
  logic m_valid, m_err;
  logic [31:0] m_word;
  logic [31:0] m_addr [3], m_next [3];
  int m_count;

  always #5 clk = ~clk;

  instr_encoder u0 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]), .op_sel(op_sel),
    .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct), .imm(imm), .target(target),
    .addr_load(addr_load), .out_valid(ov[0]), .out_ready(out_ready), .out_word(ow[0]),
    .out_addr(oa0), .word_count(wc[0]), .err(er[0]));
  instr_encoder #(.BASE_ADDR(32'h400)) u1 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]),
    .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct), .imm(imm), .target(target),
    .addr_load(addr_load), .out_valid(ov[1]), .out_ready(out_ready), .out_word(ow[1]),
    .out_addr(oa1), .word_count(wc[1]), .err(er[1]));
  instr_encoder #(.ADDR_W(4)) u2 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]),
    .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct), .imm(imm), .target(target),
    .addr_load(addr_load), .out_valid(ov[2]), .out_ready(out_ready), .out_word(ow[2]),
    .out_addr(oa2), .word_count(wc[2]), .err(er[2]));

  function automatic logic [31:0] addr_of(input int i);
    return i == 0 ? oa0 : i == 1 ? oa1 : {28'b0, oa2};
  endfunction

  function automatic logic [31:0] encode();
    int unsigned opc;
    case (op_sel)
      3'd0: opc = 35;
      3'd1: opc = 43;
      3'd3: opc = 8;
      3'd4: opc = 4;
      3'd5: opc = 2;
      default: opc = 0;
    endcase
    if (op_sel == 3'd5) return opc * 32'h0400_0000 + target;
    if (op_sel == 3'd2) return rs * 32'h20_0000 + rt * 32'h1_0000 + rd * 32'h800 + shamt * 32'h40 + funct;
    return opc * 32'h0400_0000 + rs * 32'h20_0000 + rt * 32'h1_0000 + imm;
  endfunction

  function automatic logic exp_ready();
    return !addr_load && (!m_valid || out_ready);
  endfunction

  task automatic step();
    logic a, leg;
    a = in_valid && exp_ready();
    leg = op_sel < 3'd6;
    @(posedge clk);
    if (!rst_n) begin
      m_valid = 0; m_err = 0; m_word = 0; m_count = 0;
      for (int i = 0; i < 3; i++) begin m_addr[i] = 0; m_next[i] = BASE[i]; end
    end else begin
      m_err = a && !leg;
      if (a && leg) begin
        m_word = encode();
        for (int i = 0; i < 3; i++) begin
          m_addr[i] = m_next[i];
          m_next[i] = (m_next[i] + 4) & MASK[i];
        end
        m_valid = 1;
        if (m_count < 65535) m_count++;
      end else if (out_ready) m_valid = 0;
      if (addr_load) for (int i = 0; i < 3; i++) m_next[i] = BASE[i];
    end
    #1;
  endtask

  task automatic idle();
    in_valid = 0; addr_load = 0; op_sel = 0; rs = 0; rt = 0; rd = 0; shamt = 0; funct = 0; imm = 0; target = 0;
  endtask

  task automatic send(input logic [2:0] o, input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                      input logic [5:0] f, input logic [15:0] im, input logic [25:0] tg);
    in_valid = 1; op_sel = o; rs = s; rt = t; rd = d; shamt = 0; funct = f; imm = im; target = tg;
  endtask

  task automatic do_reset();
    idle(); rst_n = 0; out_ready = 1;
    step();
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0; idle(); out_ready = 0;
    step(); step();
    for (int i = 0; i < 3; i++) begin
      tests += 5;
      if (ov[i] !== 1'b0) begin fails++; $display("FAIL reset_valid[%0d]: got %b expected 0", i, ov[i]); end
      if (ow[i] !== 32'h0) begin fails++; $display("FAIL reset_word[%0d]: got %h expected 0", i, ow[i]); end
      if (addr_of(i) !== 32'h0) begin fails++; $display("FAIL reset_addr[%0d]: got %h expected 0", i, addr_of(i)); end
      if (wc[i] !== 16'h0) begin fails++; $display("FAIL reset_count[%0d]: got %h expected 0", i, wc[i]); end
      if (er[i] !== 1'b0) begin fails++; $display("FAIL reset_err[%0d]: got %b expected 0", i, er[i]); end
    end
  endtask

  task automatic test_addi();
    do_reset();
    send(3'd3, 5'd0, 5'd8, 5'd0, 6'd0, 16'd5, 26'd0);
    #1;
    tests++;
    if (rdy[0] !== 1'b1) begin fails++; $display("FAIL addi_ready: got %b expected 1", rdy[0]); end
    step();
    tests += 4;
    if (ow[0] !== 32'h2008_0005) begin fails++; $display("FAIL addi_word: got %h expected 20080005", ow[0]); end
    if (oa0 !== 32'h0) begin fails++; $display("FAIL addi_addr: got %h expected 0", oa0); end
    if (wc[0] !== 16'd1) begin fails++; $display("FAIL addi_count: got %0d expected 1", wc[0]); end
    if (ov[0] !== 1'b1) begin fails++; $display("FAIL addi_valid: got %b expected 1", ov[0]); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] ops [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic [15:0] ims [5] = '{16'd4, 16'd8, 16'd0, 16'hFFFF, 16'd0};
    logic [31:0] words [5] = '{32'h8D09_0004, 32'hAD09_0008, 32'h0109_5020, 32'h1109_FFFF, 32'h0800_0010};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      send(ops[k], 5'd8, 5'd9, 5'd10, 6'h20, ims[k], 26'h10);
      step();
      tests += 3;
      if (ow[0] !== words[k]) begin fails++; $display("FAIL b2b_word[%0d]: got %h expected %h", k, ow[0], words[k]); end
      if (oa0 !== 32'(k * 4)) begin fails++; $display("FAIL b2b_addr[%0d]: got %h expected %h", k, oa0, k * 4); end
      if (ov[0] !== 1'b1) begin fails++; $display("FAIL b2b_valid[%0d]: got %b expected 1", k, ov[0]); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    send(3'd3, 5'd1, 5'd2, 5'd0, 6'd0, 16'h1234, 26'd0);
    out_ready = 0;
    step();
    send(3'd0, 5'd3, 5'd4, 5'd0, 6'd0, 16'h0040, 26'd0);
    for (int k = 0; k < 3; k++) begin
      #1;
      tests++;
      if (rdy[0] !== 1'b0) begin fails++; $display("FAIL bp_ready[%0d]: got %b expected 0", k, rdy[0]); end
      step();
      tests += 3;
      if (ow[0] !== 32'h2022_1234) begin fails++; $display("FAIL bp_word[%0d]: got %h expected 20221234", k, ow[0]); end
      if (oa0 !== 32'h0) begin fails++; $display("FAIL bp_addr[%0d]: got %h expected 0", k, oa0); end
      if (ov[0] !== 1'b1) begin fails++; $display("FAIL bp_valid[%0d]: got %b expected 1", k, ov[0]); end
    end
    out_ready = 1;
    #1;
    tests++;
    if (rdy[0] !== 1'b1) begin fails++; $display("FAIL bp_release_ready: got %b expected 1", rdy[0]); end
    step();
    tests += 2;
    if (ow[0] !== 32'h8C64_0040) begin fails++; $display("FAIL bp_next_word: got %h expected 8c640040", ow[0]); end
    if (oa0 !== 32'h4) begin fails++; $display("FAIL bp_next_addr: got %h expected 4", oa0); end
    idle();
    step();
    tests++;
    if (ov[0] !== 1'b0) begin fails++; $display("FAIL bp_drain: got %b expected 0", ov[0]); end
  endtask

  task automatic test_illegal();
    do_reset();
    send(3'd3, 5'd0, 5'd1, 5'd0, 6'd0, 16'd1, 26'd0);
    step();
    send(3'd6, 5'd0, 5'd1, 5'd0, 6'd0, 16'd2, 26'd0);
    step();
    tests += 3;
    if (er[0] !== 1'b1) begin fails++; $display("FAIL ill_err: got %b expected 1", er[0]); end
    if (ov[0] !== 1'b0) begin fails++; $display("FAIL ill_valid: got %b expected 0", ov[0]); end
    if (wc[0] !== 16'd1) begin fails++; $display("FAIL ill_count: got %0d expected 1", wc[0]); end
    send(3'd3, 5'd0, 5'd1, 5'd0, 6'd0, 16'd3, 26'd0);
    step();
    tests += 3;
    if (er[0] !== 1'b0) begin fails++; $display("FAIL ill_err_pulse: got %b expected 0", er[0]); end
    if (oa0 !== 32'h4) begin fails++; $display("FAIL ill_next_addr: got %h expected 4", oa0); end
    if (ov[0] !== 1'b1) begin fails++; $display("FAIL ill_next_valid: got %b expected 1", ov[0]); end
  endtask

  task automatic test_addr_load();
    do_reset();
    send(3'd3, 5'd0, 5'd1, 5'd0, 6'd0, 16'd1, 26'd0);
    step(); step();
    addr_load = 1;
    #1;
    tests++;
    if (rdy[1] !== 1'b0) begin fails++; $display("FAIL load_ready: got %b expected 0", rdy[1]); end
    step();
    tests++;
    if (ov[1] !== 1'b0) begin fails++; $display("FAIL load_valid: got %b expected 0", ov[1]); end
    addr_load = 0;
    step();
    tests += 3;
    if (oa1 !== 32'h400) begin fails++; $display("FAIL load_addr_base400: got %h expected 400", oa1); end
    if (oa0 !== 32'h0) begin fails++; $display("FAIL load_addr_base0: got %h expected 0", oa0); end
    if (wc[1] !== 16'd3) begin fails++; $display("FAIL load_count: got %0d expected 3", wc[1]); end
  endtask

  task automatic test_wrap();
    logic [3:0] exp [5] = '{4'h0, 4'h4, 4'h8, 4'hC, 4'h0};
    do_reset();
    send(3'd5, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h3FF_FFFF);
    for (int k = 0; k < 5; k++) begin
      step();
      tests++;
      if (oa2 !== exp[k]) begin fails++; $display("FAIL wrap_addr[%0d]: got %h expected %h", k, oa2, exp[k]); end
    end
  endtask

  task automatic test_midreset();
    do_reset();
    send(3'd1, 5'd5, 5'd6, 5'd0, 6'd0, 16'h00AA, 26'd0);
    out_ready = 0;
    step();
    tests++;
    if (ov[0] !== 1'b1) begin fails++; $display("FAIL mr_held: got %b expected 1", ov[0]); end
    rst_n = 0;
    step();
    tests += 4;
    if (ov[0] !== 1'b0) begin fails++; $display("FAIL mr_valid: got %b expected 0", ov[0]); end
    if (ow[0] !== 32'h0) begin fails++; $display("FAIL mr_word: got %h expected 0", ow[0]); end
    if (oa0 !== 32'h0) begin fails++; $display("FAIL mr_addr: got %h expected 0", oa0); end
    if (wc[0] !== 16'h0) begin fails++; $display("FAIL mr_count: got %h expected 0", wc[0]); end
    rst_n = 1;
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      rst_n = ($urandom % 64) != 0;
      in_valid = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      addr_load = ($urandom % 16) == 0;
      op_sel = 3'($urandom_range(0, 7));
      rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom); shamt = 5'($urandom);
      funct = 6'($urandom); imm = 16'($urandom); target = 26'($urandom);
      #1;
      for (int i = 0; i < 3; i++) begin
        tests++;
        if (rdy[i] !== exp_ready()) begin fails++; $display("FAIL rnd_ready[%0d] n=%0d: got %b expected %b", i, n, rdy[i], exp_ready()); end
      end
      step();
      for (int i = 0; i < 3; i++) begin
        tests += 5;
        if (ov[i] !== m_valid) begin fails++; $display("FAIL rnd_valid[%0d] n=%0d: got %b expected %b", i, n, ov[i], m_valid); end
        if (er[i] !== m_err) begin fails++; $display("FAIL rnd_err[%0d] n=%0d: got %b expected %b", i, n, er[i], m_err); end
        if (ow[i] !== m_word) begin fails++; $display("FAIL rnd_word[%0d] n=%0d: got %h expected %h", i, n, ow[i], m_word); end
        if (addr_of(i) !== m_addr[i]) begin fails++; $display("FAIL rnd_addr[%0d] n=%0d: got %h expected %h", i, n, addr_of(i), m_addr[i]); end
        if (wc[i] !== 16'(m_count)) begin fails++; $display("FAIL rnd_count[%0d] n=%0d: got %0d expected %0d", i, n, wc[i], m_count); end
      end
    end
  endtask

  initial begin
    rst_n = 0; out_ready = 0; idle();
    test_reset();
    test_addi();
    test_back_to_back();
    test_backpressure();
    test_illegal();
    test_addr_load();
    test_wrap();
    test_midreset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
